pixel_stream_packer: RTL and testbench
======================================

Name: pixel_stream_packer

Overview:
- Upstream feeder for the edge-detection chip.
- Accepts one 8-bit grayscale pixel per handshake in raster order and quantizes it to 5 bits.
- Packs five consecutive pixels into one group and buffers groups in a small FIFO.
- Presents groups with a valid/ready handshake on the chip's five-lane pixel bus, flagging the final group of each 20x20 frame with load_end.

Parameters:
- IN_WIDTH, 8, input pixel width.
- BIT_LENGTH, 5, quantized pixel width.
- LANES, 5, pixels per output group.
- FRAME_PIXELS, 400, pixels per frame (IMG_DIM*IMG_DIM); must be a multiple of LANES.
- FIFO_DEPTH, 4, group FIFO depth (power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  packer can accept a pixel.
- in_sof  in  1  start-of-frame marker; qualified by in_valid.
- in_pixel  in  IN_WIDTH  raw pixel.
- out_valid  out  1  group available.
- out_ready  in  1  consumer takes the group.
- pixel_out0..pixel_out4  out  BIT_LENGTH each  group lanes; lane0 is the earliest pixel.
- load_end  out  1  the group on the bus is the last group of the frame.
- frame_err  out  1  one-cycle pulse on a frame resync error.

Behaviour:
- Clock and reset: single clock domain, clk; reset is asynchronous and active-low. While reset is low:
  - all counters, staging registers and FIFO pointers clear;
  - out_valid=0, load_end=0, frame_err=0, pixel_out*=0.
- in_ready is 1 from the first cycle after reset is released.
- Accept: a pixel is accepted when in_valid && in_ready at posedge clk.
- Quantization: q = min((in_pixel + 4) >> 3, 31), computed with a 9-bit intermediate. Examples: 0→0, 3→0, 4→1, 251→31, 255→31 (saturated).
- lane_cnt (0..LANES-1):
  - An accept with lane_cnt<LANES-1 writes q into staging[lane_cnt] and increments lane_cnt.
  - An accept with lane_cnt==LANES-1 pushes {staging[0..3], q, last} into the FIFO and resets lane_cnt to 0.
- grp_cnt (0..FRAME_PIXELS/LANES-1) counts pushed groups.
  - last = (grp_cnt == FRAME_PIXELS/LANES-1).
  - grp_cnt wraps to 0 after the last group is pushed.
- in_ready = !(lane_cnt==LANES-1 && fifo_full) && !drain.
  - No same-cycle pop lookahead: a full FIFO blocks the fifth pixel even if out_ready=1.
- drain: set when the last group is pushed; cleared when that group pops. Frames never interleave in the FIFO.
- Output side:
  - out_valid = !fifo_empty; pixel_out* and load_end come from the FIFO head.
  - A pop occurs on out_valid && out_ready.
  - Head data must hold stable while out_valid && !out_ready.
- Latency: a group whose fifth pixel is accepted at edge N is visible on the outputs after edge N when the FIFO was empty. One cycle of latency from the final accept.
- Simultaneous push and pop in one cycle: the FIFO count is unchanged; both operations take effect.
- in_sof handling (when the pixel is accepted):
  - If in_sof arrives with lane_cnt==0 and grp_cnt==0: normal frame start.
  - If in_sof arrives with lane_cnt!=0 or grp_cnt!=0: discard the partial staging, pulse frame_err for one cycle, and restart the counters so that this pixel becomes pixel 0 of the new frame. Groups already in the FIFO are kept.
  - in_sof is ignored while in_ready=0.
- A reset asserted mid-frame discards everything; the next accepted pixel is pixel 0 regardless of in_sof.

Decomposition:
- Shared package canny_pkg holds IMG_DIM=20, BIT_LENGTH, TOTAL_REG, LANES, the group struct {pix[LANES], last}, and the quantize function.
- Sub-module group_fifo: synchronous FIFO for the group struct, FIFO_DEPTH entries, with full/empty flags and async active-low reset.

Test Plan:
- Reset with out_ready=1, then stream pixels 8,16,24,32,40 back-to-back → one cycle after the fifth accept: out_valid=1, pixel_out0..4=1,2,3,4,5, load_end=0.
- Inputs 0,3,4,251,255 → lanes 0,0,1,31,31 (rounding and saturation).
- Full 400-pixel frame with out_ready=1 → exactly 80 groups; load_end=1 only on group 80; in_ready=0 from the last push until that group pops.
- Hold out_ready=0 and stream 25 pixels → 4 groups buffered; in_ready drops at lane_cnt==4; outputs stay stable; raising out_ready drains groups in order, then the fifth group is accepted.
- in_sof asserted on pixel 7 of a frame → frame_err pulses one cycle; pixels 5–6 are discarded; the next group holds pixels 7–11 quantized; load_end arrives 80 groups after the resync.
- Assert reset low with 3 groups in the FIFO → out_valid=0 immediately; after release the FIFO is empty, in_ready=1, and counters restart.

Source files
------------

// File: rtl/canny_pkg.sv
// Shared constants, group payload and pixel quantizer for the edge-detection front end.
package canny_pkg;

  localparam int unsigned IMG_DIM    = 20;
  localparam int unsigned TOTAL_REG  = IMG_DIM * IMG_DIM;
  localparam int unsigned IN_WIDTH   = 8;
  localparam int unsigned BIT_LENGTH = 5;
  localparam int unsigned LANES      = 5;
  localparam int unsigned GROUPS     = TOTAL_REG / LANES;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned QMAX       = (1 << BIT_LENGTH) - 1;

  typedef struct packed {
    logic [LANES-1:0][BIT_LENGTH-1:0] pix;
    logic                             last;
  } group_t;

  // Round-to-nearest divide by 8 with saturation at the top code.
  function automatic logic [BIT_LENGTH-1:0] quantize(input logic [IN_WIDTH-1:0] p);
    logic [IN_WIDTH:0] s;
    s = (IN_WIDTH+1)'(p) + (IN_WIDTH+1)'(4);
    s = s >> 3;
    if (s > (IN_WIDTH+1)'(QMAX)) return BIT_LENGTH'(QMAX);
    return BIT_LENGTH'(s);
  endfunction

endpackage

// File: rtl/pixel_stream_packer_if.sv
// Pixel input handshake and five-lane group output bus of the packer.
interface pixel_stream_packer_if;
  import canny_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic                  in_sof;
  logic [IN_WIDTH-1:0]   in_pixel;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIT_LENGTH-1:0] pixel_out0;
  logic [BIT_LENGTH-1:0] pixel_out1;
  logic [BIT_LENGTH-1:0] pixel_out2;
  logic [BIT_LENGTH-1:0] pixel_out3;
  logic [BIT_LENGTH-1:0] pixel_out4;
  logic                  load_end;
  logic                  frame_err;

  modport master (
    output in_valid, in_sof, in_pixel, out_ready,
    input  in_ready, out_valid, pixel_out0, pixel_out1, pixel_out2, pixel_out3,
           pixel_out4, load_end, frame_err
  );

  modport slave (
    input  in_valid, in_sof, in_pixel, out_ready,
    output in_ready, out_valid, pixel_out0, pixel_out1, pixel_out2, pixel_out3,
           pixel_out4, load_end, frame_err
  );
endinterface

// File: rtl/group_fifo.sv
// Synchronous FIFO of pixel groups; head entry is read combinationally.
module group_fifo
  import canny_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_push,
  input  group_t i_data,
  input  logic   i_pop,
  output group_t o_data,
  output logic   o_full,
  output logic   o_empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  group_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_rd)      r_count <= r_count + CW'(1);
      else if (w_rd && !w_wr) r_count <= r_count - CW'(1);
    end
  end
endmodule

// File: rtl/pixel_stream_packer.sv
// Quantizes 8-bit raster pixels to 5 bits, packs five per group and queues groups
// for the five-lane pixel bus, marking the final group of each frame.
module pixel_stream_packer
  import canny_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  pixel_stream_packer_if.slave bus
);
  localparam int unsigned LW = $clog2(LANES);
  localparam int unsigned GW = $clog2(GROUPS);

  logic [LW-1:0]         r_lane;
  logic [GW-1:0]         r_grp;
  logic [BIT_LENGTH-1:0] r_stage [LANES-1];
  logic                  r_drain;
  logic                  r_frame_err;

  logic [BIT_LENGTH-1:0] w_q;
  logic                  w_lane_top;
  logic                  w_last;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_resync;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  group_t                w_grp;
  group_t                w_head;

  assign w_q        = quantize(bus.in_pixel);
  assign w_lane_top = (r_lane == LW'(LANES - 1));
  assign w_last     = (r_grp == GW'(GROUPS - 1));
  assign w_in_ready = !(w_lane_top && w_full) && !r_drain;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_resync   = w_accept && bus.in_sof && ((r_lane != '0) || (r_grp != '0));
  assign w_push     = w_accept && !w_resync && w_lane_top;
  assign w_pop      = !w_empty && bus.out_ready;

  always_comb begin
    w_grp = '0;
    for (int unsigned i = 0; i < LANES - 1; i++) w_grp.pix[i] = r_stage[i];
    w_grp.pix[LANES-1] = w_q;
    w_grp.last         = w_last;
  end

  // A misplaced start-of-frame makes the current pixel pixel 0 of a fresh frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lane <= '0;
      r_grp  <= '0;
      for (int unsigned i = 0; i < LANES - 1; i++) r_stage[i] <= '0;
    end else if (w_resync) begin
      r_stage[0] <= w_q;
      r_lane     <= LW'(1);
      r_grp      <= '0;
    end else if (w_accept) begin
      if (w_lane_top) begin
        r_lane <= '0;
        r_grp  <= w_last ? '0 : r_grp + GW'(1);
      end else begin
        for (int unsigned i = 0; i < LANES - 1; i++)
          if (r_lane == LW'(i)) r_stage[i] <= w_q;
        r_lane <= r_lane + LW'(1);
      end
    end
  end

  // Input stalls from the last push of a frame until that group leaves the FIFO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drain     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_resync;
      if (w_push && w_last)          r_drain <= 1'b1;
      else if (w_pop && w_head.last) r_drain <= 1'b0;
    end
  end

  group_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (reset),
    .i_push (w_push),
    .i_data (w_grp),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = !w_empty;
  assign bus.pixel_out0 = w_head.pix[0];
  assign bus.pixel_out1 = w_head.pix[1];
  assign bus.pixel_out2 = w_head.pix[2];
  assign bus.pixel_out3 = w_head.pix[3];
  assign bus.pixel_out4 = w_head.pix[4];
  assign bus.load_end   = w_head.last;
  assign bus.frame_err  = r_frame_err;
endmodule

// File: tb/tb_pixel_stream_packer.sv
// Scoreboard bench for pixel_stream_packer: a pixel-count frame model predicts groups
// and resync pulses, and a negedge monitor checks them as the DUT presents them.
module tb_pixel_stream_packer;
  import canny_pkg::*;

  logic clk;
  logic rst_n;
  pixel_stream_packer_if bus();

  pixel_stream_packer dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int rdy_mode = 1;            // 0: hold off, 1: always ready, 2: random
  logic [25:0] exp_q[$];
  int m_cur[$];
  int m_pos = 0;
  int err_pending = 0;
  int grp_seen = 0;
  int loads_seen = 0;
  int errs_seen = 0;
  logic [25:0] last_grp = '0;
  logic [25:0] held = '0;
  logic hold_v = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom % 3) != 0;
      endcase
      @(posedge clk);
      #2;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] cur_vec();
    return {bus.load_end, bus.pixel_out4, bus.pixel_out3, bus.pixel_out2,
            bus.pixel_out1, bus.pixel_out0};
  endfunction

  // Frame model: counts pixels into the frame; every fifth pixel closes a group.
  task automatic model_accept(input int p, input bit sof);
    int q;
    logic [25:0] e;
    if (sof && m_pos != 0) begin
      err_pending++;
      m_cur.delete();
      m_pos = 0;
    end
    q = (p + 4) / 8;
    if (q > 31) q = 31;
    m_cur.push_back(q);
    m_pos++;
    if (m_cur.size() == 5) begin
      e = {1'(m_pos == int'(TOTAL_REG)), 5'(m_cur[4]), 5'(m_cur[3]), 5'(m_cur[2]),
           5'(m_cur[1]), 5'(m_cur[0])};
      exp_q.push_back(e);
      m_cur.delete();
      if (m_pos == int'(TOTAL_REG)) m_pos = 0;
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  task automatic send_px(input int p, input bit sof);
    int waits;
    bit done;
    waits = 0;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pixel = 8'(p);
    bus.in_sof   = sof;
    while (!done) begin
      #1;
      if (bus.in_ready === 1'b1) begin
        model_accept(p, sof);
        done = 1'b1;
      end else if (waits >= 2000) begin
        checks++;
        errors++;
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected acceptance", waits);
        done = 1'b1;
      end
      sync();
      waits++;
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (bus.frame_err === 1'b1) begin
        checks++;
        errs_seen++;
        if (err_pending > 0) err_pending--;
        else begin
          errors++;
          $display("FAIL frame_err: got unexpected pulse expected none at %0t", $time);
        end
      end
      if (hold_v) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(cur_vec()), 32'(held));
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        grp_seen++;
        if (bus.load_end) loads_seen++;
        last_grp = cur_vec();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL group: got unexpected %h expected nothing at %0t", cur_vec(), $time);
        end else begin
          chk("group", 32'(cur_vec()), 32'(exp_q.pop_front()));
        end
      end
      hold_v = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
      held   = cur_vec();
    end
  end

  initial begin
    logic [25:0] want;
    int snap;
    bit sof;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pixel = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(cur_vec()), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    sync();

    // Five ramp pixels: group visible right after the fifth accept.
    send_px(8, 0); send_px(16, 0); send_px(24, 0); send_px(32, 0); send_px(40, 0);
    #1;
    chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
    want = {1'b0, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
    chk("lat_group", 32'(cur_vec()), 32'(want));
    sync();

    // Rounding and saturation corners.
    send_px(0, 0); send_px(3, 0); send_px(4, 0); send_px(251, 0); send_px(255, 0);
    idle(2);
    want = {1'b0, 5'd31, 5'd31, 5'd1, 5'd0, 5'd0};
    chk("quant_group", 32'(last_grp), 32'(want));

    // Complete the 400-pixel frame.
    for (int i = 10; i < 400; i++) send_px(int'($urandom_range(0, 255)), 0);
    #1;
    chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #3;
    chk("drain_release", 32'(bus.in_ready), 32'd1);
    sync();
    idle(3);
    chk("frame_groups", 32'(grp_seen), 32'd80);
    chk("frame_loads", 32'(loads_seen), 32'd1);

    // Start-of-frame on pixel 7 resyncs the frame.
    for (int i = 0; i < 7; i++) send_px(int'($urandom_range(0, 255)), i == 0);
    send_px(int'($urandom_range(0, 255)), 1);
    for (int i = 1; i < 400; i++) send_px(int'($urandom_range(0, 255)), 0);
    idle(5);
    chk("resync_errs", 32'(errs_seen), 32'd1);
    chk("resync_groups", 32'(grp_seen), 32'd161);
    chk("resync_loads", 32'(loads_seen), 32'd2);

    // Backpressure: four groups fill the FIFO and the fifth closing pixel stalls.
    rdy_mode = 0;
    sync();
    snap = grp_seen;
    fork
      begin
        for (int i = 0; i < 25; i++) send_px(int'($urandom_range(0, 255)), i == 0);
      end
      begin
        repeat (40) @(posedge clk);
        #1;
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_no_pop", 32'(grp_seen), 32'(snap));
        rdy_mode = 1;
      end
    join
    idle(10);
    chk("stall_groups", 32'(grp_seen), 32'(snap + 5));

    // Reset with three groups buffered discards everything.
    rdy_mode = 0;
    sync();
    for (int i = 0; i < 15; i++) send_px(int'($urandom_range(0, 255)), 0);
    idle(2);
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", 32'(cur_vec()), 32'd0);
    exp_q.delete();
    m_cur.delete();
    m_pos = 0;
    err_pending = 0;
    idle(2);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    sync();
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) send_px(int'($urandom_range(0, 255)), 0);
    idle(3);
    chk("post_rst_group_left", 32'(exp_q.size()), 32'd0);

    // Random traffic with gaps, random backpressure and sporadic start-of-frame.
    rdy_mode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 4 == 0) idle(int'($urandom_range(1, 3)));
      sof = ($urandom % 200) == 0;
      send_px(int'($urandom_range(0, 255)), sof);
    end
    rdy_mode = 1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) sync();
    idle(2);
    chk("final_groups_left", 32'(exp_q.size()), 32'd0);
    chk("final_err_left", 32'(err_pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
